// File: rtl/sdffe_write_arbiter.sv
// sdffe_write_arbiter
//
// Purpose:
//   Shares one WIDTH-bit write-enabled register with synchronous reset among
//   N requesters. Requests are arbitrated round-robin. A requester can hold
//   LOCK to keep ownership for back-to-back bursts. A separate clear port
//   loads CLR_VALUE. The module computes the register's enable, data and sync
//   clear, and it also holds the register itself.
//
// Ports:
//   CLK       in   1        rising-edge clock
//   SRST_N    in   1        synchronous active-low reset
//   REQ       in   N        per-requester write request, held until GNT
//   LOCK      in   N        with REQ, keep ownership after this write
//   WDATA     in   N*WIDTH  write data, requester i on [i*WIDTH +: WIDTH]
//   CLR_REQ   in   1        request a load of CLR_VALUE, held until CLR_ACK
//   GNT       out  N        combinational one-hot/zero grant
//   CLR_ACK   out  1        combinational clear acceptance
//   Q         out  WIDTH    shared register contents
//   LOCKED    out  1        registered, arbiter is in the OWN state
//   OWNER_ID  out  IDW      registered lock holder, 0 when not locked

module sdffe_write_arbiter #(
    parameter int                N          = 4,
    parameter int                WIDTH      = 2,
    parameter logic [WIDTH-1:0]  SRST_VALUE = WIDTH'(2),
    parameter logic [WIDTH-1:0]  CLR_VALUE  = WIDTH'(0),
    localparam int               IDW        = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 SRST_N,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0]         LOCK,
    input  logic [N*WIDTH-1:0]   WDATA,
    input  logic                 CLR_REQ,
    output logic [N-1:0]         GNT,
    output logic                 CLR_ACK,
    output logic [WIDTH-1:0]     Q,
    output logic                 LOCKED,
    output logic [IDW-1:0]       OWNER_ID
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [WIDTH-1:0]   q_q, q_d;

    logic               found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     win_next;
    logic               win_lock;
    logic [WIDTH-1:0]   win_data;

    logic               own_req;
    logic               own_lock;
    logic [IDW-1:0]     own_next;
    logic [WIDTH-1:0]   own_data;

    logic [N-1:0]       gnt_c;
    logic               clr_ack_c;

    // Round-robin search, done in two passes. The first pass scans the
    // requesters from ptr up to N-1. The second pass scans 0 up to ptr-1.
    // Two passes give the circular order without a modulo on the index.
    // The successor index wraps from N-1 to 0, so ptr never leaves 0..N-1
    // even when N is not a power of two.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_next = '0;
        win_lock = 1'b0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && REQ[i] && (i >= int'(ptr_q))) begin
                found    = 1'b1;
                win_idx  = IDW'(i);
                win_next = (i == N - 1) ? '0 : IDW'(i + 1);
                win_lock = LOCK[i];
                win_data = WDATA[i*WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && REQ[i] && (i < int'(ptr_q))) begin
                found    = 1'b1;
                win_idx  = IDW'(i);
                win_next = (i == N - 1) ? '0 : IDW'(i + 1);
                win_lock = LOCK[i];
                win_data = WDATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // Select the current lock holder's request, lock, data and successor
    // index. These signals are used only while the arbiter is in OWN.
    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_next = '0;
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IDW'(i)) begin
                own_req  = REQ[i];
                own_lock = LOCK[i];
                own_next = (i == N - 1) ? '0 : IDW'(i + 1);
                own_data = WDATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grant decisions and next-state computation.
    //
    // In IDLE, a pending clear wins over every write. Otherwise the
    // round-robin winner is granted, and it enters OWN if it also holds LOCK.
    //
    // In OWN, only the owner can be granted. A pending clear waits until the
    // lock is released. The owner leaves OWN at the first edge where it drops
    // LOCK, whether or not it writes in that cycle.
    //
    // Grants are suppressed during reset so that no transfer is reported
    // while the register is being forced to SRST_VALUE.
    always_comb begin
        gnt_c     = '0;
        clr_ack_c = 1'b0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        q_d       = q_q;

        case (state_q)
            IDLE: begin
                if (CLR_REQ) begin
                    clr_ack_c = 1'b1;
                    q_d       = CLR_VALUE;
                end else if (found) begin
                    for (int i = 0; i < N; i++) begin
                        if (win_idx == IDW'(i)) begin
                            gnt_c[i] = 1'b1;
                        end
                    end
                    q_d   = win_data;
                    ptr_d = win_next;
                    if (win_lock) begin
                        state_d = OWN;
                        owner_d = win_idx;
                    end
                end
            end
            OWN: begin
                if (own_req) begin
                    for (int i = 0; i < N; i++) begin
                        if (owner_q == IDW'(i)) begin
                            gnt_c[i] = 1'b1;
                        end
                    end
                    q_d   = own_data;
                    ptr_d = own_next;
                end
                if (!own_lock) begin
                    state_d = IDLE;
                    owner_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase

        if (!SRST_N) begin
            gnt_c     = '0;
            clr_ack_c = 1'b0;
        end
    end

    // All state lives in this one block. A synchronous reset returns the
    // arbiter to IDLE with the pointer at requester 0, so any requests still
    // pending after reset are arbitrated again from the start.
    always_ff @(posedge CLK) begin
        if (!SRST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            q_q     <= SRST_VALUE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            q_q     <= q_d;
        end
    end

    assign GNT      = gnt_c;
    assign CLR_ACK  = clr_ack_c;
    assign Q        = q_q;
    assign LOCKED   = (state_q == OWN);
    assign OWNER_ID = owner_q;

endmodule

// File: tb/tb_sdffe_write_arbiter.sv
// tb_sdffe_write_arbiter
//
// Purpose:
//   Directed testbench for sdffe_write_arbiter. It instantiates an N=4 arbiter
//   as the main device and an N=3 arbiter for the pointer-wrap case.
//
//   For the N=4 instance, the stimulus process pushes each expected transfer
//   (grant, clear acknowledge, resulting Q) into a queue. A separate monitor
//   process pops an entry whenever the arbiter reports a transfer, compares
//   it, and then checks Q one cycle later. Idle cycles, registered status and
//   the N=3 instance are checked directly by the stimulus process.
//
// Ports: none.

module tb_sdffe_write_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic       clr_ack;
        logic [1:0] q;
    } exp_t;

    logic        clk;
    logic        srst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [7:0]  wdata;
    logic        clr_req;
    logic [3:0]  gnt;
    logic        clr_ack;
    logic [1:0]  q;
    logic        locked;
    logic [1:0]  owner_id;

    logic [2:0]  req3;
    logic [2:0]  lock3;
    logic [5:0]  wdata3;
    logic        clr_req3;
    logic [2:0]  gnt3;
    logic        clr_ack3;
    logic [1:0]  q3;
    logic        locked3;
    logic [1:0]  owner_id3;

    int          checks;
    int          errors;
    exp_t        sb_queue[$];
    logic        pend_valid;
    logic [1:0]  pend_q;

    sdffe_write_arbiter #(
        .N          (4),
        .WIDTH      (2),
        .SRST_VALUE (2'd2),
        .CLR_VALUE  (2'd0)
    ) dut (
        .CLK      (clk),
        .SRST_N   (srst_n),
        .REQ      (req),
        .LOCK     (lock),
        .WDATA    (wdata),
        .CLR_REQ  (clr_req),
        .GNT      (gnt),
        .CLR_ACK  (clr_ack),
        .Q        (q),
        .LOCKED   (locked),
        .OWNER_ID (owner_id)
    );

    sdffe_write_arbiter #(
        .N          (3),
        .WIDTH      (2),
        .SRST_VALUE (2'd2),
        .CLR_VALUE  (2'd0)
    ) dut3 (
        .CLK      (clk),
        .SRST_N   (srst_n),
        .REQ      (req3),
        .LOCK     (lock3),
        .WDATA    (wdata3),
        .CLR_REQ  (clr_req3),
        .GNT      (gnt3),
        .CLR_ACK  (clr_ack3),
        .Q        (q3),
        .LOCKED   (locked3),
        .OWNER_ID (owner_id3)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the simulation stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout reached, run did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] pk(input logic [1:0] s3, input logic [1:0] s2,
                                      input logic [1:0] s1, input logic [1:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst_n_v, input logic [3:0] req_v,
                                 input logic [3:0] lock_v, input logic clr_v,
                                 input logic [7:0] wdata_v);
        srst_n  = rst_n_v;
        req     = req_v;
        lock    = lock_v;
        clr_req = clr_v;
        wdata   = wdata_v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectXfer(input logic [3:0] g, input logic c, input logic [1:0] qv);
        exp_t e;
        e.gnt     = g;
        e.clr_ack = c;
        e.q       = qv;
        sb_queue.push_back(e);
    endtask

    // Monitor: on every falling edge, first check the Q that the previous
    // transfer should have produced. Then, if a transfer is being reported
    // now, pop the expected entry and compare it.
    initial begin
        exp_t e;
        pend_valid = 1'b0;
        pend_q     = '0;
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                checkOutput("q_after_xfer", 32'(q), 32'(pend_q));
                pend_valid = 1'b0;
            end
            if ((gnt != 4'b0000) || clr_ack) begin
                if (sb_queue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_xfer gnt=%b clr_ack=%b expected no transfer at %0t",
                             gnt, clr_ack, $time);
                end else begin
                    e = sb_queue.pop_front();
                    checkOutput("xfer_gnt", 32'(gnt), 32'(e.gnt));
                    checkOutput("xfer_clr_ack", 32'(clr_ack), 32'(e.clr_ack));
                    pend_q     = e.q;
                    pend_valid = 1'b1;
                end
            end
        end
    end

    // Directed stimulus for the N=4 instance, followed by the N=3 wrap case.
    initial begin
        checks   = 0;
        errors   = 0;
        req3     = '0;
        lock3    = '0;
        wdata3   = '0;
        clr_req3 = 1'b0;

        // Reset held for two cycles with all requests and a clear pending.
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, pk(3, 2, 1, 0));
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_clr_ack", 32'(clr_ack), 32'h0);
        tick();
        checkOutput("rst_q", 32'(q), 32'h2);
        checkOutput("rst_locked", 32'(locked), 32'h0);
        checkOutput("rst_owner", 32'(owner_id), 32'h0);
        checkOutput("rst_gnt2", 32'(gnt), 32'h0);
        checkOutput("rst_clr_ack2", 32'(clr_ack), 32'h0);
        tick();
        checkOutput("rst_q2", 32'(q), 32'h2);

        // Release: the clear is accepted ahead of the writes.
        expectXfer(4'b0000, 1'b1, 2'd0);
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, pk(3, 2, 1, 0));
        tick();

        // All requests held: grants rotate 0,1,2,3,0.
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, pk(3, 2, 1, 0));
        for (int k = 0; k < 5; k++) begin
            expectXfer(4'b0001 << (k % 4), 1'b0, 2'(k % 4));
            tick();
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, pk(3, 2, 1, 0));
        checkOutput("idle_gnt", 32'(gnt), 32'h0);
        tick();
        checkOutput("idle_q_hold", 32'(q), 32'h0);

        // Requester 2 locks. While it owns the register, requester 0 and the
        // clear must wait.
        expectXfer(4'b0100, 1'b0, 2'd2);
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, pk(3, 2, 1, 0));
        tick();
        checkOutput("lock2_locked", 32'(locked), 32'h1);
        checkOutput("lock2_owner", 32'(owner_id), 32'h2);
        expectXfer(4'b0100, 1'b0, 2'd1);
        applyStimulus(1'b1, 4'b0101, 4'b0100, 1'b1, pk(3, 1, 1, 0));
        checkOutput("own_defers_clr", 32'(clr_ack), 32'h0);
        tick();
        checkOutput("lock2_locked_b", 32'(locked), 32'h1);
        expectXfer(4'b0100, 1'b0, 2'd3);
        applyStimulus(1'b1, 4'b0101, 4'b0100, 1'b1, pk(3, 3, 1, 0));
        tick();
        expectXfer(4'b0100, 1'b0, 2'd2);
        applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b1, pk(3, 2, 1, 0));
        tick();
        checkOutput("unlock2_locked", 32'(locked), 32'h0);
        checkOutput("unlock2_owner", 32'(owner_id), 32'h0);
        expectXfer(4'b0000, 1'b1, 2'd0);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b1, pk(3, 2, 1, 0));
        tick();
        expectXfer(4'b0001, 1'b0, 2'd3);
        applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0, pk(3, 2, 1, 3));
        tick();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, pk(3, 2, 1, 3));
        tick();

        // Requester 1 locks and then stops requesting. Requester 3 must stay
        // blocked until the lock is released.
        expectXfer(4'b0010, 1'b0, 2'd2);
        applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b0, pk(0, 0, 2, 0));
        tick();
        checkOutput("lock1_owner", 32'(owner_id), 32'h1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'b1000, 4'b0010, 1'b0, pk(1, 0, 2, 0));
            checkOutput("lock1_idle_gnt", 32'(gnt), 32'h0);
            tick();
            checkOutput("lock1_q_hold", 32'(q), 32'h2);
            checkOutput("lock1_locked", 32'(locked), 32'h1);
        end
        applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0, pk(1, 0, 2, 0));
        checkOutput("lock1_exit_gnt", 32'(gnt), 32'h0);
        tick();
        checkOutput("lock1_exit_locked", 32'(locked), 32'h0);
        expectXfer(4'b1000, 1'b0, 2'd1);
        tick();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, pk(1, 0, 2, 0));
        tick();

        // Bring PTR to 3, then check the wrap from 3 to 0.
        expectXfer(4'b0100, 1'b0, 2'd1);
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0, pk(2, 1, 0, 3));
        tick();
        expectXfer(4'b1000, 1'b0, 2'd2);
        applyStimulus(1'b1, 4'b1001, 4'b0000, 1'b0, pk(2, 1, 0, 3));
        tick();
        expectXfer(4'b0001, 1'b0, 2'd3);
        tick();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, pk(2, 1, 0, 3));
        tick();

        // Reset pulse while requester 2 holds the lock.
        expectXfer(4'b0100, 1'b0, 2'd3);
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, pk(0, 3, 0, 0));
        tick();
        checkOutput("pre_rst_locked", 32'(locked), 32'h1);
        checkOutput("pre_rst_owner", 32'(owner_id), 32'h2);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b0, pk(0, 3, 0, 0));
        checkOutput("mid_rst_gnt", 32'(gnt), 32'h0);
        tick();
        checkOutput("post_rst_locked", 32'(locked), 32'h0);
        checkOutput("post_rst_owner", 32'(owner_id), 32'h0);
        checkOutput("post_rst_q", 32'(q), 32'h2);
        expectXfer(4'b0010, 1'b0, 2'd1);
        applyStimulus(1'b1, 4'b0110, 4'b0000, 1'b0, pk(0, 0, 1, 0));
        tick();
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0, pk(0, 0, 1, 0));
        tick();

        // N=3 instance: PTR goes to 2 and then wraps to 0 (not to 3).
        wdata3 = {2'd3, 2'd0, 2'd1};
        req3   = 3'b010;
        #1;
        checkOutput("n3_gnt1", 32'(gnt3), 32'h2);
        tick();
        checkOutput("n3_q1", 32'(q3), 32'h0);
        req3 = 3'b101;
        #1;
        checkOutput("n3_gnt2", 32'(gnt3), 32'h4);
        tick();
        checkOutput("n3_q2", 32'(q3), 32'h3);
        #1;
        checkOutput("n3_gnt_wrap", 32'(gnt3), 32'h1);
        tick();
        checkOutput("n3_q_wrap", 32'(q3), 32'h1);
        #1;
        checkOutput("n3_gnt_after_wrap", 32'(gnt3), 32'h4);
        tick();
        checkOutput("n3_q3", 32'(q3), 32'h3);
        req3 = 3'b000;
        tick();
        tick();

        checkOutput("scoreboard_drained", 32'(sb_queue.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
